// File: rtl/mvprod_pkg.sv
// Shared types and helpers for the MVProd chunk sequencer slice.
package mvprod_pkg;

  typedef enum logic [1:0] {
    LOAD,
    START,
    RUN,
    DONE
  } seq_state_t;

  typedef logic signed [7:0] byte_t;

  // Number of WorkingRegs-wide chunks in an input vector.
  function automatic int unsigned num_chunks(input int unsigned in_vec_length,
                                             input int unsigned working_regs);
    return in_vec_length / working_regs;
  endfunction

endpackage

// File: rtl/mvprod_chunk_sequencer_if.sv
// Bundles the upstream, MVProd-side and downstream signals of the sequencer.
interface mvprod_chunk_sequencer_if
  import mvprod_pkg::*;
#(
  parameter int unsigned OutVecLength = 8,
  parameter int unsigned WorkingRegs  = 4
);

  logic                                in_valid;
  logic [WorkingRegs-1:0][7:0]         in_data;
  logic                                in_ready;
  logic                                mv_data_ready;
  logic [WorkingRegs-1:0][7:0]         mv_chunk;
  logic                                req_chunk_in;
  logic                                req_chunk_ptr_rst;
  logic                                req_chunk_out;
  byte_t                               write_out_data;
  logic                                out_vector_valid;
  logic                                out_valid;
  logic [OutVecLength-1:0][7:0]        out_data;
  logic                                out_ready;
  logic                                protocol_err;

  // Sequencer side.
  modport slave (
    input  in_valid, in_data, req_chunk_in, req_chunk_ptr_rst, req_chunk_out,
           write_out_data, out_vector_valid, out_ready,
    output in_ready, mv_data_ready, mv_chunk, out_valid, out_data, protocol_err
  );

  // Environment side (upstream, MVProd and downstream together).
  modport master (
    output in_valid, in_data, req_chunk_in, req_chunk_ptr_rst, req_chunk_out,
           write_out_data, out_vector_valid, out_ready,
    input  in_ready, mv_data_ready, mv_chunk, out_valid, out_data, protocol_err
  );

endinterface

// File: rtl/vec_chunk_buffer.sv
// Chunk register file: one synchronous write port, one asynchronous read port,
// synchronous clear.
module vec_chunk_buffer #(
  parameter int unsigned Depth       = 4,
  parameter int unsigned WorkingRegs = 4,
  parameter int unsigned AddrW       = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                        clk_in,
  input  logic                        clr,
  input  logic                        we,
  input  logic [AddrW-1:0]            waddr,
  input  logic [WorkingRegs-1:0][7:0] wdata,
  input  logic [AddrW-1:0]            raddr,
  output logic [WorkingRegs-1:0][7:0] rdata
);

  logic [WorkingRegs-1:0][7:0] mem [Depth];

  // Clear all entries or store one chunk.
  always_ff @(posedge clk_in) begin
    if (clr) begin
      for (int unsigned i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mvprod_chunk_sequencer.sv
// Loads an input vector in chunks, starts MVProd, serves its chunk requests,
// collects its output bytes and hands the finished vector downstream.
module mvprod_chunk_sequencer
  import mvprod_pkg::*;
#(
  parameter int unsigned InVecLength  = 16,
  parameter int unsigned OutVecLength = 8,
  parameter int unsigned WorkingRegs  = 4
) (
  input logic                      clk_in,
  input logic                      rst_in,
  mvprod_chunk_sequencer_if.slave  bus
);

  localparam int unsigned NumChunks = num_chunks(InVecLength, WorkingRegs);
  localparam int unsigned ChunkAw   = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int unsigned OutAw     = (OutVecLength > 1) ? $clog2(OutVecLength) : 1;
  localparam logic [ChunkAw-1:0] LastChunk = ChunkAw'(NumChunks - 1);
  localparam logic [OutAw-1:0]   LastOut   = OutAw'(OutVecLength - 1);

  if (InVecLength % WorkingRegs != 0) begin : g_len_check
    $error("InVecLength must be a multiple of WorkingRegs");
  end

  seq_state_t         state, next_state;
  logic [ChunkAw-1:0] wr_ptr, rd_ptr;
  logic [OutAw-1:0]   out_idx;
  byte_t              out_buf [OutVecLength];
  logic               err_q;
  logic               load_fire, last_load, out_fire, last_out, err_set;

  // Handshake qualifiers and protocol-error detection.
  always_comb begin
    load_fire = (state == LOAD) && bus.in_valid;
    last_load = load_fire && (wr_ptr == LastChunk);
    out_fire  = (state == RUN) && bus.req_chunk_out;
    last_out  = out_fire && (out_idx == LastOut);
    err_set   = ((state != RUN) &&
                 (bus.req_chunk_in || bus.req_chunk_ptr_rst || bus.req_chunk_out)) ||
                (bus.out_vector_valid && !bus.req_chunk_out) ||
                (out_fire && bus.out_vector_valid && (out_idx != LastOut)) ||
                (last_out && !bus.out_vector_valid);
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= LOAD;
    else        state <= next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state        = state;
    bus.in_ready      = 1'b0;
    bus.mv_data_ready = 1'b0;
    bus.out_valid     = 1'b0;
    case (state)
      LOAD: begin
        bus.in_ready = 1'b1;
        if (last_load) next_state = START;
      end
      START: begin
        bus.mv_data_ready = 1'b1;
        next_state        = RUN;
      end
      RUN: begin
        if (last_out) next_state = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) next_state = LOAD;
      end
      default: next_state = LOAD;
    endcase
  end

  // Pointers, output byte collection and sticky error flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      out_idx <= '0;
      err_q   <= 1'b0;
      for (int unsigned j = 0; j < OutVecLength; j++) out_buf[j] <= '0;
    end else begin
      if (load_fire) wr_ptr <= wr_ptr + 1'b1;
      if ((state == DONE) && bus.out_ready) wr_ptr <= '0;
      if (state == START) begin
        rd_ptr  <= '0;
        out_idx <= '0;
      end
      if (state == RUN) begin
        if (bus.req_chunk_ptr_rst)  rd_ptr <= '0;
        else if (bus.req_chunk_in)  rd_ptr <= (rd_ptr == LastChunk) ? '0 : rd_ptr + 1'b1;
      end
      if (out_fire) begin
        out_buf[out_idx] <= bus.write_out_data;
        out_idx          <= out_idx + 1'b1;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  // Expose collected bytes; they only change in RUN, so they hold through DONE.
  always_comb begin
    for (int unsigned j = 0; j < OutVecLength; j++) bus.out_data[j] = out_buf[j];
  end

  assign bus.protocol_err = err_q;

  vec_chunk_buffer #(
    .Depth       (NumChunks),
    .WorkingRegs (WorkingRegs),
    .AddrW       (ChunkAw)
  ) u_in_buf (
    .clk_in (clk_in),
    .clr    (rst_in),
    .we     (load_fire),
    .waddr  (wr_ptr),
    .wdata  (bus.in_data),
    .raddr  (rd_ptr),
    .rdata  (bus.mv_chunk)
  );

endmodule

// File: tb/tb_mvprod_chunk_sequencer.sv
// Directed bench for mvprod_chunk_sequencer (8-byte input, 4-byte output, 4-byte chunks).
module tb_mvprod_chunk_sequencer;
  import mvprod_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;

  mvprod_chunk_sequencer_if #(.OutVecLength(4), .WorkingRegs(4)) bus_if ();

  mvprod_chunk_sequencer #(
    .InVecLength  (8),
    .OutVecLength (4),
    .WorkingRegs  (4)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus_if)
  );

  always #5 clk_in = ~clk_in;

  logic [3:0][7:0] chunk_lo, chunk_hi, exp_out, held_out;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.in_valid          = 1'b0;
    bus_if.in_data           = '0;
    bus_if.req_chunk_in      = 1'b0;
    bus_if.req_chunk_ptr_rst = 1'b0;
    bus_if.req_chunk_out     = 1'b0;
    bus_if.write_out_data    = '0;
    bus_if.out_vector_valid  = 1'b0;
    bus_if.out_ready         = 1'b0;
  endtask

  // Loads two chunks starting at byte value base and steps into RUN.
  task automatic load_vec(input int base);
    for (int c = 0; c < 2; c++) begin
      bus_if.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) bus_if.in_data[i] = 8'(base + c * 4 + i);
      step();
    end
    bus_if.in_valid = 1'b0;
    step();
  endtask

  task automatic write_byte(input byte_t b, input logic ovv);
    bus_if.req_chunk_out    = 1'b1;
    bus_if.write_out_data   = b;
    bus_if.out_vector_valid = ovv;
    step();
    bus_if.req_chunk_out    = 1'b0;
    bus_if.out_vector_valid = 1'b0;
  endtask

  task automatic handshake();
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) step();
    rst_in = 1'b0;
    chk_cnt++; if (bus_if.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", bus_if.in_ready); else pass_cnt++;
    chk_cnt++; if (bus_if.mv_data_ready !== 1'b0) $display("FAIL reset_mv_data_ready got %0b want 0", bus_if.mv_data_ready); else pass_cnt++;
    chk_cnt++; if (bus_if.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", bus_if.out_valid); else pass_cnt++;
    chk_cnt++; if (bus_if.protocol_err !== 1'b0) $display("FAIL reset_protocol_err got %0b want 0", bus_if.protocol_err); else pass_cnt++;
    chk_cnt++; if (bus_if.mv_chunk !== 32'h0) $display("FAIL reset_mv_chunk got %h want 0", bus_if.mv_chunk); else pass_cnt++;
    chk_cnt++; if (bus_if.out_data !== 32'h0) $display("FAIL reset_out_data got %h want 0", bus_if.out_data); else pass_cnt++;
  endtask

  task automatic test_load();
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = chunk_lo;
    step();
    chk_cnt++; if (bus_if.in_ready !== 1'b1) $display("FAIL load_mid_in_ready got %0b want 1", bus_if.in_ready); else pass_cnt++;
    bus_if.in_data = chunk_hi;
    step();
    bus_if.in_valid = 1'b0;
    chk_cnt++; if (bus_if.in_ready !== 1'b0) $display("FAIL load_in_ready_fall got %0b want 0", bus_if.in_ready); else pass_cnt++;
    chk_cnt++; if (bus_if.mv_data_ready !== 1'b1) $display("FAIL load_start_pulse got %0b want 1", bus_if.mv_data_ready); else pass_cnt++;
    step();
    chk_cnt++; if (bus_if.mv_data_ready !== 1'b0) $display("FAIL load_start_one_cycle got %0b want 0", bus_if.mv_data_ready); else pass_cnt++;
    chk_cnt++; if (bus_if.mv_chunk !== chunk_lo) $display("FAIL load_first_chunk got %h want %h", bus_if.mv_chunk, chunk_lo); else pass_cnt++;
  endtask

  task automatic test_chunk_ptr();
    bus_if.req_chunk_in = 1'b1;
    step();
    chk_cnt++; if (bus_if.mv_chunk !== chunk_hi) $display("FAIL ptr_advance got %h want %h", bus_if.mv_chunk, chunk_hi); else pass_cnt++;
    step();
    chk_cnt++; if (bus_if.mv_chunk !== chunk_lo) $display("FAIL ptr_wrap got %h want %h", bus_if.mv_chunk, chunk_lo); else pass_cnt++;
    step();
    chk_cnt++; if (bus_if.mv_chunk !== chunk_hi) $display("FAIL ptr_advance2 got %h want %h", bus_if.mv_chunk, chunk_hi); else pass_cnt++;
    bus_if.req_chunk_ptr_rst = 1'b1;
    step();
    bus_if.req_chunk_in      = 1'b0;
    bus_if.req_chunk_ptr_rst = 1'b0;
    chk_cnt++; if (bus_if.mv_chunk !== chunk_lo) $display("FAIL ptr_rst_priority got %h want %h", bus_if.mv_chunk, chunk_lo); else pass_cnt++;
  endtask

  task automatic test_output();
    exp_out = {8'sd40, -8'sd30, 8'sd20, 8'sd10};
    for (int k = 0; k < 4; k++) begin
      write_byte(byte_t'(exp_out[k]), k == 3);
      if (k < 3) begin
        chk_cnt++; if (bus_if.out_valid !== 1'b0) $display("FAIL out_valid_early byte %0d got %0b want 0", k, bus_if.out_valid); else pass_cnt++;
      end
    end
    chk_cnt++; if (bus_if.out_valid !== 1'b1) $display("FAIL out_valid_rise got %0b want 1", bus_if.out_valid); else pass_cnt++;
    chk_cnt++; if (bus_if.out_data !== exp_out) $display("FAIL out_data got %h want %h", bus_if.out_data, exp_out); else pass_cnt++;
    held_out = bus_if.out_data;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_cnt++; if (bus_if.out_data !== exp_out || bus_if.out_valid !== 1'b1)
        $display("FAIL out_hold cycle %0d got %h/%0b want %h/1", k, bus_if.out_data, bus_if.out_valid, exp_out); else pass_cnt++;
    end
    handshake();
    chk_cnt++; if (bus_if.in_ready !== 1'b1) $display("FAIL handshake_in_ready got %0b want 1", bus_if.in_ready); else pass_cnt++;
    chk_cnt++; if (bus_if.out_valid !== 1'b0) $display("FAIL handshake_out_valid got %0b want 0", bus_if.out_valid); else pass_cnt++;
    chk_cnt++; if (bus_if.protocol_err !== 1'b0) $display("FAIL clean_run_err got %0b want 0", bus_if.protocol_err); else pass_cnt++;
  endtask

  task automatic test_protocol_err();
    load_vec(32);
    write_byte(8'sd1, 1'b0);
    chk_cnt++; if (bus_if.protocol_err !== 1'b0) $display("FAIL err_before got %0b want 0", bus_if.protocol_err); else pass_cnt++;
    write_byte(8'sd2, 1'b1);
    chk_cnt++; if (bus_if.protocol_err !== 1'b1) $display("FAIL err_early_marker got %0b want 1", bus_if.protocol_err); else pass_cnt++;
    write_byte(8'sd3, 1'b0);
    write_byte(8'sd4, 1'b1);
    chk_cnt++; if (bus_if.out_valid !== 1'b1) $display("FAIL err_run_completes got %0b want 1", bus_if.out_valid); else pass_cnt++;
    handshake();
    load_vec(64);
    exp_out = {8'sd8, 8'sd7, 8'sd6, 8'sd5};
    for (int k = 0; k < 4; k++) write_byte(byte_t'(exp_out[k]), k == 3);
    chk_cnt++; if (bus_if.out_data !== exp_out) $display("FAIL err_next_vector got %h want %h", bus_if.out_data, exp_out); else pass_cnt++;
    chk_cnt++; if (bus_if.protocol_err !== 1'b1) $display("FAIL err_sticky got %0b want 1", bus_if.protocol_err); else pass_cnt++;
    handshake();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    chk_cnt++; if (bus_if.protocol_err !== 1'b0) $display("FAIL err_cleared got %0b want 0", bus_if.protocol_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    load_vec(100);
    write_byte(8'sd99, 1'b0);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    chk_cnt++; if (bus_if.in_ready !== 1'b1) $display("FAIL midrst_in_ready got %0b want 1", bus_if.in_ready); else pass_cnt++;
    chk_cnt++; if (bus_if.out_valid !== 1'b0) $display("FAIL midrst_out_valid got %0b want 0", bus_if.out_valid); else pass_cnt++;
    chk_cnt++; if (bus_if.out_data !== 32'h0) $display("FAIL midrst_out_data got %h want 0", bus_if.out_data); else pass_cnt++;
    chk_cnt++; if (bus_if.mv_chunk !== 32'h0) $display("FAIL midrst_mv_chunk got %h want 0", bus_if.mv_chunk); else pass_cnt++;
    load_vec(17);
    chk_cnt++; if (bus_if.mv_chunk !== 32'h14131211) $display("FAIL fresh_chunk got %h want 14131211", bus_if.mv_chunk); else pass_cnt++;
    exp_out = {-8'sd1, 8'sd127, -8'sd128, 8'sd3};
    for (int k = 0; k < 4; k++) write_byte(byte_t'(exp_out[k]), k == 3);
    chk_cnt++; if (bus_if.out_valid !== 1'b1) $display("FAIL fresh_out_valid got %0b want 1", bus_if.out_valid); else pass_cnt++;
    chk_cnt++; if (bus_if.out_data !== exp_out) $display("FAIL fresh_out_data got %h want %h", bus_if.out_data, exp_out); else pass_cnt++;
    chk_cnt++; if (bus_if.protocol_err !== 1'b0) $display("FAIL fresh_err got %0b want 0", bus_if.protocol_err); else pass_cnt++;
    handshake();
  endtask

  initial begin
    idle_inputs();
    chunk_lo = 32'h04030201;
    chunk_hi = 32'h08070605;
    test_reset();
    test_load();
    test_chunk_ptr();
    test_output();
    test_protocol_err();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
